// File: rtl/conv_addr_gen.sv
// conv_addr_gen: incremental ifmap/weight/output address generator with a valid/ready beat stream
module conv_addr_gen #(
  parameter int NUM_PE    = 4,
  parameter int ADDR_W    = 20,
  parameter int WT_ADDR_W = 16,
  parameter int DIM_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIM_W-1:0]           cfg_k,
  input  logic [DIM_W-1:0]           cfg_cha,
  input  logic [DIM_W-1:0]           cfg_row,
  input  logic [DIM_W-1:0]           cfg_col,
  input  logic [DIM_W-1:0]           cfg_wrow,
  input  logic [DIM_W-1:0]           cfg_wcol,
  input  logic [DIM_W-1:0]           cfg_orow,
  input  logic [DIM_W-1:0]           cfg_stride,
  input  logic [ADDR_W-1:0]          cfg_sample_area,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PE*ADDR_W-1:0]   addr_in,
  output logic [WT_ADDR_W-1:0]       addr_wt,
  output logic [WT_ADDR_W-1:0]       addr_out,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  state_t                      state_q;
  logic [DIM_W-1:0]            k_q, c_q, r_q, kcnt_q, cha_q, orow_q;
  logic [DIM_W-1:0]            k_d, c_d, r_d;
  logic [ADDR_W-1:0]           row_step_q, ch_step_q, row_off_q, ch_off_q;
  logic [ADDR_W-1:0]           row_d, ch_d, acc;
  logic [WT_ADDR_W-1:0]        wt_step_q, wt_q, kbase_q, out_q;
  logic [WT_ADDR_W-1:0]        wt_d, kbase_d;
  logic [NUM_PE*ADDR_W-1:0]    lane_q, lane_d, ain_q, ain_d;
  logic                        valid_q, first_q, last_q, busy_q, done_q;
  logic                        r_last, c_last, fin;
  assign r_last    = r_q == orow_q - ONE;
  assign c_last    = c_q == cha_q - ONE;
  assign fin       = r_last && c_last && (k_q == kcnt_q - ONE);
  assign out_valid = valid_q;
  assign addr_in   = ain_q;
  assign addr_wt   = wt_q;
  assign addr_out  = out_q;
  assign acc_first = first_q;
  assign acc_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // lane base offsets p*sample_area built as a chain of additions from the live config
  always_comb begin
    acc    = '0;
    lane_d = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      lane_d[p*ADDR_W +: ADDR_W] = acc;
      acc = acc + cfg_sample_area;
    end
  end
  // next loop position and its addresses; row innermost, then channel, then kernel
  always_comb begin
    r_d     = r_last ? '0 : r_q + ONE;
    row_d   = r_last ? '0 : row_off_q + row_step_q;
    c_d     = r_last ? (c_last ? '0 : c_q + ONE) : c_q;
    ch_d    = r_last ? (c_last ? '0 : ch_off_q + ch_step_q) : ch_off_q;
    k_d     = (r_last && c_last) ? k_q + ONE : k_q;
    wt_d    = r_last ? wt_q + wt_step_q : wt_q;
    kbase_d = (r_last && c_last) ? kbase_q + WT_ADDR_W'(orow_q) : kbase_q;
    ain_d   = '0;
    for (int p = 0; p < NUM_PE; p++)
      ain_d[p*ADDR_W +: ADDR_W] = lane_q[p*ADDR_W +: ADDR_W] + ch_d + row_d;
  end
  // control FSM with registered beat outputs; counters advance only on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= '0;
      r_q        <= '0;
      kcnt_q     <= '0;
      cha_q      <= '0;
      orow_q     <= '0;
      row_step_q <= '0;
      ch_step_q  <= '0;
      wt_step_q  <= '0;
      row_off_q  <= '0;
      ch_off_q   <= '0;
      kbase_q    <= '0;
      lane_q     <= '0;
      ain_q      <= '0;
      wt_q       <= '0;
      out_q      <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          kcnt_q     <= cfg_k;
          cha_q      <= cfg_cha;
          orow_q     <= cfg_orow;
          row_step_q <= ADDR_W'(cfg_stride) * ADDR_W'(cfg_col);
          ch_step_q  <= ADDR_W'(cfg_row) * ADDR_W'(cfg_col);
          wt_step_q  <= WT_ADDR_W'(cfg_wrow) * WT_ADDR_W'(cfg_wcol);
          lane_q     <= lane_d;
          ain_q      <= lane_d;
          k_q        <= '0;
          c_q        <= '0;
          r_q        <= '0;
          row_off_q  <= '0;
          ch_off_q   <= '0;
          kbase_q    <= '0;
          wt_q       <= '0;
          out_q      <= '0;
          first_q    <= 1'b1;
          last_q     <= cfg_cha == ONE;
          busy_q     <= 1'b1;
          if (cfg_k != '0 && cfg_cha != '0 && cfg_orow != '0) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        RUN: if (abort) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end else if (valid_q && out_ready) begin
          if (fin) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q       <= k_d;
            c_q       <= c_d;
            r_q       <= r_d;
            row_off_q <= row_d;
            ch_off_q  <= ch_d;
            kbase_q   <= kbase_d;
            wt_q      <= wt_d;
            ain_q     <= ain_d;
            out_q     <= kbase_d + WT_ADDR_W'(r_d);
            first_q   <= c_d == '0;
            last_q    <= c_d == cha_q - ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_addr_gen.sv
// tb_conv_addr_gen: randomized self-checking bench against a nested-loop beat model
module tb_conv_addr_gen;
  localparam int NP = 4, AW = 20, WW = 16, DW = 8;
  localparam int BW = NP*AW + 2*WW + 2;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [DW-1:0] cfg_k = 0, cfg_cha = 0, cfg_row = 0, cfg_col = 0, cfg_wrow = 0, cfg_wcol = 0, cfg_orow = 0, cfg_stride = 0;
  logic [AW-1:0] cfg_sample_area = 0;
  logic out_valid, acc_first, acc_last, busy, done;
  logic [NP*AW-1:0] addr_in;
  logic [WW-1:0] addr_wt, addr_out;
  int checks = 0, errors = 0;
  logic [BW-1:0] exp_q[$], got_q[$];
  conv_addr_gen #(.NUM_PE(NP), .ADDR_W(AW), .WT_ADDR_W(WW), .DIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_k(cfg_k), .cfg_cha(cfg_cha), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_wrow(cfg_wrow), .cfg_wcol(cfg_wcol), .cfg_orow(cfg_orow), .cfg_stride(cfg_stride),
    .cfg_sample_area(cfg_sample_area), .out_valid(out_valid), .out_ready(out_ready),
    .addr_in(addr_in), .addr_wt(addr_wt), .addr_out(addr_out),
    .acc_first(acc_first), .acc_last(acc_last), .busy(busy), .done(done));
  always #5 clk = ~clk;
  function automatic logic [BW-1:0] snap();
    return {addr_in, addr_wt, addr_out, acc_first, acc_last};
  endfunction
  task automatic build(input int k, cha, row, col, wrow, wcol, orow, stride, sa);
    logic [NP*AW-1:0] ai;
    logic [AW-1:0] t;
    exp_q.delete();
    for (int kk = 0; kk < k; kk++)
      for (int cc = 0; cc < cha; cc++)
        for (int rr = 0; rr < orow; rr++) begin
          for (int p = 0; p < NP; p++) begin
            t = AW'(p*sa + cc*row*col + rr*stride*col);
            ai[p*AW +: AW] = t;
          end
          exp_q.push_back({ai, WW'((kk*cha + cc)*(wrow*wcol)), WW'(kk*orow + rr), cc == 0, cc == cha-1});
        end
  endtask
  task automatic drive_cfg(input int k, cha, row, col, wrow, wcol, orow, stride, sa);
    cfg_k = DW'(k); cfg_cha = DW'(cha); cfg_row = DW'(row); cfg_col = DW'(col);
    cfg_wrow = DW'(wrow); cfg_wcol = DW'(wcol); cfg_orow = DW'(orow); cfg_stride = DW'(stride);
    cfg_sample_area = AW'(sa);
  endtask
  task automatic run(input int k, cha, row, col, wrow, wcol, orow, stride, sa,
                     input bit rnd, input bit disturb, output int nb, output int nd, output int bubbles);
    logic [BW:0] held;
    logic [BW-1:0] e;
    bit stalled, fin, rdy;
    int bound;
    build(k, cha, row, col, wrow, wcol, orow, stride, sa);
    drive_cfg(k, cha, row, col, wrow, wcol, orow, stride, sa);
    got_q.delete();
    start = 1; out_ready = 0;
    @(posedge clk); #1;
    start = 0;
    nb = 0; nd = 0; bubbles = 0; stalled = 0; fin = 0;
    bound = exp_q.size()*4 + 20;
    for (int cyc = 0; cyc < bound && !fin; cyc++) begin
      if (stalled) begin
        checks++;
        if ({out_valid, snap()} !== held) begin
          errors++;
          $display("FAIL stall_hold got=%h exp=%h", {out_valid, snap()}, held);
        end
      end
      stalled = 0;
      if (done) begin
        nd++; fin = 1; checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_state left=%0d valid=%b busy=%b exp left=0 valid=0 busy=1", exp_q.size(), out_valid, busy);
        end
      end else if (out_valid) begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        if (rdy) begin
          got_q.push_back(snap());
          nb++; checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got=%h exp=none", snap());
          end else begin
            e = exp_q.pop_front();
            if (snap() !== e) begin
              errors++;
              $display("FAIL beat%0d got=%h exp=%h", nb-1, snap(), e);
            end
          end
        end else begin
          stalled = 1;
          held = {1'b1, snap()};
        end
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bubbles++;
      end
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        drive_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, (1 << AW) - 1));
      end
      @(posedge clk); #1;
    end
    start = 0; out_ready = 0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout beats=%0d exp done within %0d cycles", nb, bound);
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_done done=%b busy=%b exp 0 0", done, busy);
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({out_valid, busy, done, snap()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, busy, done, snap()});
    end
  endtask
  task automatic test_basic();
    int nb, nd, bb;
    logic [BW-1:0] ref35;
    run(2, 3, 8, 8, 3, 3, 6, 1, 1024, 0, 0, nb, nd, bb);
    checks++; if (nb != 36) begin errors++; $display("FAIL basic_beats got=%0d exp=36", nb); end
    checks++; if (nd != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", nd); end
    checks++; if (bb != 0) begin errors++; $display("FAIL basic_bubbles got=%0d exp=0", bb); end
    ref35 = {20'd3240, 20'd2216, 20'd1192, 20'd168, 16'd45, 16'd11, 1'b0, 1'b1};
    checks++;
    if (got_q.size() < 36) begin errors++; $display("FAIL beat_1_2_5 got=missing exp=%h", ref35); end
    else if (got_q[35] !== ref35) begin errors++; $display("FAIL beat_1_2_5 got=%h exp=%h", got_q[35], ref35); end
  endtask
  task automatic test_backpressure();
    int nb, nd, bb;
    run(2, 3, 8, 8, 3, 3, 6, 1, 1024, 1, 0, nb, nd, bb);
    checks++; if (nb != 36 || nd != 1) begin errors++; $display("FAIL bp_counts got=%0d/%0d exp=36/1", nb, nd); end
  endtask
  task automatic test_stride();
    int nb, nd, bb;
    logic [AW-1:0] l0;
    run(1, 2, 8, 8, 3, 3, 3, 2, 1024, 1, 0, nb, nd, bb);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= i) begin errors++; $display("FAIL stride_lane0_%0d got=missing exp=%0d", i, 16*i); end
      else begin
        l0 = got_q[i][BW-1-(NP-1)*AW -: AW];
        if (l0 !== AW'(16*i)) begin errors++; $display("FAIL stride_lane0_%0d got=%0d exp=%0d", i, l0, 16*i); end
      end
    end
  endtask
  task automatic test_zero();
    int nb, nd, bb;
    for (int i = 0; i < 3; i++) begin
      run(i == 0 ? 0 : 2, i == 1 ? 0 : 3, 8, 8, 3, 3, i == 2 ? 0 : 6, 1, 1024, 0, 0, nb, nd, bb);
      checks++;
      if (nb != 0 || nd != 1 || bb != 0) begin
        errors++;
        $display("FAIL zero_cfg%0d beats/done/bubbles got=%0d/%0d/%0d exp=0/1/0", i, nb, nd, bb);
      end
    end
  endtask
  task automatic test_random();
    int nb, nd, bb, k, cha, orow;
    for (int i = 0; i < 5; i++) begin
      k = $urandom_range(1, 3); cha = $urandom_range(1, 4); orow = $urandom_range(1, 5);
      run(k, cha, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
          orow, $urandom_range(0, 255), $urandom_range(0, (1 << AW) - 1), 1, 0, nb, nd, bb);
      checks++;
      if (nb != k*cha*orow || nd != 1) begin errors++; $display("FAIL rand%0d got=%0d/%0d exp=%0d/1", i, nb, nd, k*cha*orow); end
    end
  endtask
  task automatic test_start_busy();
    int nb, nd, bb;
    run(2, 3, 8, 8, 3, 3, 6, 1, 1024, 1, 1, nb, nd, bb);
    checks++; if (nb != 36 || nd != 1) begin errors++; $display("FAIL start_busy got=%0d/%0d exp=36/1", nb, nd); end
  endtask
  task automatic test_abort();
    int nb, nd, bb, seen;
    logic [BW-1:0] e;
    build(2, 3, 8, 8, 3, 3, 6, 1, 1024);
    drive_cfg(2, 3, 8, 8, 3, 3, 6, 1, 1024);
    start = 1; @(posedge clk); #1; start = 0; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || snap() !== e) begin
        errors++;
        $display("FAIL abort_pre%0d got=%b/%h exp=1/%h", i, out_valid, snap(), e);
      end
      @(posedge clk); #1;
    end
    abort = 1; out_ready = 0;
    @(posedge clk); #1;
    abort = 0;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_exit got=%b exp=000", {out_valid, busy, done}); end
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (done || out_valid || busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet got=%0d active cycles exp=0", seen); end
    run(2, 3, 8, 8, 3, 3, 6, 1, 1024, 0, 0, nb, nd, bb);
    checks++; if (nb != 36 || nd != 1) begin errors++; $display("FAIL abort_restart got=%0d/%0d exp=36/1", nb, nd); end
  endtask
  task automatic test_abort_start_idle();
    drive_cfg(2, 3, 8, 8, 3, 3, 6, 1, 1024);
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_start_idle got=%b exp=000", {out_valid, busy, done}); end
  endtask
  task automatic test_async_reset();
    drive_cfg(2, 3, 8, 8, 3, 3, 6, 1, 1024);
    start = 1; @(posedge clk); #1; start = 0; out_ready = 1;
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || snap() === '0) begin errors++; $display("FAIL async_pre busy=%b beat=%h exp busy=1 beat nonzero", busy, snap()); end
    rst_n = 0; #1;
    checks++;
    if ({out_valid, busy, done, snap()} !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", {out_valid, busy, done, snap()}); end
    out_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL async_after got=%b exp=000", {out_valid, busy, done}); end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_stride();
    test_zero();
    test_random();
    test_start_busy();
    test_abort();
    test_abort_start_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
